// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
// Write-side master for the register file. It picks at most one result per
// cycle for the single write port: either the in-order pipeline writeback or
// a buffered long-latency (div/load) result held in a small FIFO. When the
// FIFO head has waited too long, a starvation guard stalls the pipe so the
// buffered results can drain. It also publishes a mask of registers that
// have FIFO-pending writes, for use by the hazard logic.
module wb_write_arbiter #(
    parameter int unsigned RAW        = 5,
    parameter int unsigned DW         = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_pipe_wr_en,
    input  logic [RAW-1:0]             i_pipe_wr_reg,
    input  logic [DW-1:0]              i_pipe_wr_data,
    output logic                       o_pipe_stall,
    input  logic                       i_lu_valid,
    input  logic [RAW-1:0]             i_lu_reg,
    input  logic [DW-1:0]              i_lu_data,
    output logic                       o_lu_ready,
    output logic                       o_write_en,
    output logic [RAW-1:0]             o_write_reg,
    output logic [DW-1:0]              o_write_data,
    output logic [(2**RAW)-1:0]        o_busy_mask,
    output logic [$clog2(DEPTH):0]     o_fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(STARVE_LIM + 1);
    localparam int unsigned NR = 2 ** RAW;

    // Source chosen for the write port in the current cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_FIFO = 2'd2
    } src_e;

    // FIFO storage; fifo_vld marks occupied slots so the busy mask can be
    // built directly from the slots without re-deriving occupancy from pointers.
    logic [RAW-1:0]   fifo_reg  [DEPTH];
    logic [DW-1:0]    fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_vld;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [WW-1:0]    wait_cnt;

    logic             write_en_q;
    logic [RAW-1:0]   write_reg_q;
    logic [DW-1:0]    write_data_q;

    logic             empty;
    logic             full;
    logic             stall;
    logic             lu_push;
    logic             fifo_pop;
    src_e             src;
    logic [NR-1:0]    busy_mask;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign stall   = !empty && (wait_cnt >= WW'(STARVE_LIM));
    // Handshake happens on valid && ready; x0 results are accepted but dropped.
    assign lu_push = i_lu_valid && !full && (i_lu_reg != '0);

    // Per-cycle write-port arbitration: starving FIFO, then pipe, then FIFO
    always_comb begin
        src      = SRC_NONE;
        fifo_pop = 1'b0;
        if (stall) begin
            src      = SRC_FIFO;
            fifo_pop = 1'b1;
        end else if (i_pipe_wr_en) begin
            src      = SRC_PIPE;
        end else if (!empty) begin
            src      = SRC_FIFO;
            fifo_pop = 1'b1;
        end
    end

    // Registered write port; address/data hold when no write is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            case (src)
                SRC_FIFO: begin
                    write_en_q   <= 1'b1;
                    write_reg_q  <= fifo_reg[rd_ptr];
                    write_data_q <= fifo_data[rd_ptr];
                end
                SRC_PIPE: begin
                    if (i_pipe_wr_reg != '0) begin
                        write_en_q   <= 1'b1;
                        write_reg_q  <= i_pipe_wr_reg;
                        write_data_q <= i_pipe_wr_data;
                    end else begin
                        write_en_q   <= 1'b0;
                    end
                end
                default: begin
                    write_en_q <= 1'b0;
                end
            endcase
        end
    end

    // FIFO slots, pointers and occupancy. Push and pop never target the same
    // slot: equal pointers mean empty (no pop) or full (no push).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_reg[i]  <= '0;
                fifo_data[i] <= '0;
            end
            fifo_vld <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (fifo_pop) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            if (lu_push) begin
                fifo_reg[wr_ptr]  <= i_lu_reg;
                fifo_data[wr_ptr] <= i_lu_data;
                fifo_vld[wr_ptr]  <= 1'b1;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (lu_push && !fifo_pop) begin
                count <= count + CW'(1);
            end else if (!lu_push && fifo_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Starvation timer: counts cycles a non-empty FIFO goes unpopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (empty || fifo_pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt < WW'(STARVE_LIM)) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Busy mask: OR of one-hot destinations of occupied FIFO slots
    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i]) begin
                busy_mask[fifo_reg[i]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    assign o_pipe_stall = stall;
    assign o_lu_ready   = !full;
    assign o_write_en   = write_en_q;
    assign o_write_reg  = write_reg_q;
    assign o_write_data = write_data_q;
    assign o_busy_mask  = busy_mask;
    assign o_fifo_count = count;

endmodule
